// File: rtl/spi_rx_fifo.sv
// Show-ahead receive FIFO behind the SPI slave, with frame-length masking.
// Define SPI_RX_FIFO_IRQ_EN to build the registered threshold/overflow irq.
module spi_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [15:0]   i_data,
  input  logic [3:0]    i_len,
  input  logic          i_rd,
  output logic [15:0]   o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level,
  input  logic          i_flush,
  output logic          o_ovf,
  input  logic          i_ovf_clr,
  input  logic [AW:0]   i_thr,
  output logic          o_irq
);

  localparam logic [AW:0] ONE = 1;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_nxt, rd_nxt;
  logic [AW:0] lvl_nxt;
  logic        empty, full;
  logic        do_wr, do_rd;
  logic        ovf_set, ovf_nxt, ovf_q;
  logic [4:0]  sh;
  logic [15:0] mask;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  // Equivalent to ((1 << (len+1)) - 1) taken 17 bits wide.
  assign sh   = {1'b0, i_len} + 5'd1;
  assign mask = ~(16'hFFFF << sh);

  // A pop in the same cycle frees the slot a full write needs.
  assign do_rd   = i_rd && !empty && !i_flush;
  assign do_wr   = i_wr && (!full || do_rd) && !i_flush;
  assign ovf_set = i_wr && full && !do_rd && !i_flush;
  assign ovf_nxt = ovf_set || (ovf_q && !i_ovf_clr);

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (i_flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_wr) wr_nxt = wr_ptr + ONE;
      if (do_rd) rd_nxt = rd_ptr + ONE;
    end
  end

  assign lvl_nxt = wr_nxt - rd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= i_data & mask;
  end

  assign o_data  = mem[rd_ptr[AW-1:0]];
  assign o_empty = empty;
  assign o_full  = full;
  assign o_level = wr_ptr - rd_ptr;
  assign o_ovf   = ovf_q;

`ifdef SPI_RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= ((i_thr != '0) && (lvl_nxt >= i_thr)) || ovf_nxt;
  end

  assign o_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{i_thr, lvl_nxt};
  assign o_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed vector bench for spi_rx_fifo (DEPTH=8).
// Irq expectations apply only when SPI_RX_FIFO_IRQ_EN is defined.
module tb_spi_rx_fifo;

`ifdef SPI_RX_FIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wr, i_rd, i_flush, i_ovf_clr;
  logic [15:0] i_data;
  logic [3:0]  i_len;
  logic [3:0]  i_thr;
  logic [15:0] o_data;
  logic        o_empty, o_full, o_ovf, o_irq;
  logic [3:0]  o_level;

  int checks = 0;
  int errors = 0;

  spi_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .i_len     (i_len),
    .i_rd      (i_rd),
    .o_data    (o_data),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_level   (o_level),
    .i_flush   (i_flush),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr),
    .i_thr     (i_thr),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic [3:0]  len;
    logic        rd;
    logic        fl;
    logic        clr;
    logic [3:0]  thr;
    logic [15:0] dout;
    logic        cd;
    logic [3:0]  lvl;
    logic        ovf;
    logic        irq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic wr, input logic [15:0] din, input logic [3:0] len,
    input logic rd, input logic fl, input logic clr,
    input logic [3:0] thr, input logic [15:0] dout, input logic cd,
    input logic [3:0] lvl, input logic ovf, input logic irq);
    vec_t v;
    v.wr = wr; v.din = din; v.len = len; v.rd = rd;
    v.fl = fl; v.clr = clr; v.thr = thr; v.dout = dout;
    v.cd = cd; v.lvl = lvl; v.ovf = ovf; v.irq = irq;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    if (v.cd) chk("data", idx, o_data, v.dout);
    chk("level", idx, {12'd0, o_level}, {12'd0, v.lvl});
    chk("empty", idx, {15'd0, o_empty}, {15'd0, v.lvl == 4'd0});
    chk("full",  idx, {15'd0, o_full},  {15'd0, v.lvl == 4'd8});
    chk("ovf",   idx, {15'd0, o_ovf},   {15'd0, v.ovf});
    chk("irq",   idx, {15'd0, o_irq},   {15'd0, IRQ ? v.irq : 1'b0});
  endtask

  task automatic idle();
    i_wr = 0; i_rd = 0; i_flush = 0; i_ovf_clr = 0;
    i_data = '0; i_len = 4'd15; i_thr = '0;
  endtask

  initial begin
    vec_t v;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v = '{default: '0};
    chk_all(-1, v);
    rst = 1'b0;

    // basic order, read while empty
    add(1, 16'h1234, 15, 0, 0, 0, 0, 16'h1234, 1, 1, 0, 0);
    add(1, 16'h5678, 15, 0, 0, 0, 0, 16'h1234, 1, 2, 0, 0);
    add(1, 16'h9ABC, 15, 0, 0, 0, 0, 16'h1234, 1, 3, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h5678, 1, 2, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h9ABC, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // masking
    add(1, 16'hABCD,  7, 0, 0, 0, 0, 16'h00CD, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 16'hFFFF,  3, 0, 0, 0, 0, 16'h000F, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 16'hFFFF,  0, 0, 0, 0, 0, 16'h0001, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // fill, overflow, clear
    for (int i = 1; i <= 8; i++)
      add(1, 16'h1000 + 16'(i - 1), 15, 0, 0, 0, 0,
          16'h1000, 1, 4'(i), 0, 0);
    add(1, 16'hDEAD, 15, 0, 0, 0, 0, 16'h1000, 1, 8, 1, 1);
    add(0, 16'h0000, 15, 0, 0, 1, 0, 16'h1000, 1, 8, 0, 0);
    // full with write and read together
    add(1, 16'h2000, 15, 1, 0, 0, 0, 16'h1001, 1, 8, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h1001 + 16'(k), 1,
          4'(8 - k), 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h2000, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // empty with write and read together
    add(1, 16'h3000, 15, 1, 0, 0, 0, 16'h3000, 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // wrap at level 1
    add(1, 16'h4000, 15, 0, 0, 0, 0, 16'h4000, 1, 1, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(1, 16'h4000 + 16'(k), 15, 1, 0, 0, 0,
          16'h4000 + 16'(k), 1, 1, 0, 0);
    add(0, 16'h0000, 15, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    // flush with write at level 5
    for (int i = 1; i <= 5; i++)
      add(1, 16'h5000 + 16'(i), 15, 0, 0, 0, 0,
          16'h5001, 1, 4'(i), 0, 0);
    add(1, 16'h5999, 15, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 16'h6000, 15, 0, 0, 0, 0, 16'h6000, 1, 1, 0, 0);
    // set beats clear; flush keeps ovf
    for (int i = 2; i <= 8; i++)
      add(1, 16'h6000 + 16'(i), 15, 0, 0, 0, 0,
          16'h6000, 1, 4'(i), 0, 0);
    add(1, 16'hBEEF, 15, 0, 0, 1, 0, 16'h6000, 1, 8, 1, 1);
    add(0, 16'h0000, 15, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 1);
    add(0, 16'h0000, 15, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    // threshold irq
    for (int i = 1; i <= 4; i++)
      add(1, 16'hA000 + 16'(i), 15, 0, 0, 0, 4, 16'hA001, 1,
          4'(i), 0, i == 4);
    add(0, 16'h0000, 15, 1, 0, 0, 4, 16'hA002, 1, 3, 0, 0);
    add(1, 16'hA005, 15, 0, 0, 0, 4, 16'hA002, 1, 4, 0, 1);
    for (int i = 5; i <= 8; i++)
      add(1, 16'hA001 + 16'(i), 15, 0, 0, 0, 0, 16'hA002, 1,
          4'(i), 0, 0);
    add(1, 16'hFACE, 15, 0, 0, 0, 0, 16'hA002, 1, 8, 1, 1);
    add(0, 16'h0000, 15, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);

    foreach (vq[i]) begin
      v = vq[i];
      i_wr = v.wr; i_data = v.din; i_len = v.len; i_rd = v.rd;
      i_flush = v.fl; i_ovf_clr = v.clr; i_thr = v.thr;
      @(posedge clk);
      #1;
      chk_all(i, v);
    end
    idle();

    // asynchronous reset in the middle of operation
    i_wr = 1; i_data = 16'h7001;
    @(posedge clk);
    #1;
    i_data = 16'h7002;
    @(posedge clk);
    #1;
    idle();
    chk("pre-rst level", 0, {12'd0, o_level}, 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst level", 0, {12'd0, o_level}, 16'd0);
    chk("rst empty", 0, {15'd0, o_empty}, 16'd1);
    chk("rst ovf", 0, {15'd0, o_ovf}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    i_wr = 1; i_data = 16'h7777;
    @(posedge clk);
    #1;
    idle();
    chk("post-rst data", 0, o_data, 16'h7777);
    chk("post-rst level", 0, {12'd0, o_level}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
